// File: rtl/brq_pkg.sv
// Shared types for the load/store unit.
//   lsu_type_e  : access width requested by ID/EX
//   lsu_state_e : bus-engine state
//   lsu_be()    : byte-enable pattern for phase A or phase B of an access
package brq_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_GNT_A    = 3'd1,
        WAIT_RVALID_A = 3'd2,
        WAIT_GNT_B    = 3'd3,
        WAIT_RVALID_B = 3'd4
    } lsu_state_e;

    // Phase B only exists for split accesses, i.e. word at off!=0 or half at
    // off==3, so its patterns cover the bytes that spilled into the next word.
    function automatic logic [3:0] lsu_be(lsu_type_e t, logic [1:0] off, logic phase_b);
        logic [3:0] be;
        be = 4'b0000;
        case (t)
            LSU_WORD: be = phase_b ? (4'b1111 >> (3'd4 - {1'b0, off})) : (4'b1111 << off);
            LSU_HALF: be = phase_b ? 4'b0001 : (4'b0011 << off);
            LSU_BYTE: be = 4'b0001 << off;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/brq_lsu_load_align.sv
// Load data alignment and extension (purely combinational).
//   rdata_i    : bus read data of the final phase
//   rdata_q_i  : phase A read data (used only when split_i)
//   split_i    : access was split into two bus transactions
//   off_i      : byte offset of the original address
//   type_i     : access width
//   sign_ext_i : sign-extend instead of zero-extend
//   result_o   : 32-bit register-file value
module brq_lsu_load_align
    import brq_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] rdata_q_i,
    input  logic        split_i,
    input  logic [1:0]  off_i,
    input  lsu_type_e   type_i,
    input  logic        sign_ext_i,
    output logic [31:0] result_o
);

    logic [63:0] wide;
    logic [31:0] raw;

    // Split: phase B word sits above phase A word; shifting the pair down
    // brings the addressed byte to bit 0.
    always_comb begin
        wide = split_i ? ({rdata_i, rdata_q_i} >> {off_i, 3'b000})
                       : ({32'd0, rdata_i}      >> {off_i, 3'b000});
        raw  = wide[31:0];
        case (type_i)
            LSU_HALF: result_o = {{16{sign_ext_i & raw[15]}}, raw[15:0]};
            LSU_BYTE: result_o = {{24{sign_ext_i & raw[7]}},  raw[7:0]};
            default:  result_o = raw;
        endcase
    end

endmodule

// File: rtl/brq_lsu_resp_unit.sv
// Load/store bus engine with writeback response.
//   lsu_*_i          : one request from ID/EX, held until lsu_req_done_o
//   lsu_req_done_o   : grant of the final bus phase
//   busy_o           : engine not idle
//   data_*           : data-memory req/gnt/rvalid interface
//   lsu_resp_*_o     : one-cycle completion pulse and error
//   rf_we/wdata_lsu_o: load writeback
// Misaligned accesses are split into two word-aligned transactions when
// MisalignEn=1; otherwise a single aligned transaction is issued and the
// completion is flagged as an error.
module brq_lsu_resp_unit
    import brq_pkg::*;
#(
    parameter logic MisalignEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  lsu_type_e   lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_req_done_o,
    output logic        busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        rf_we_lsu_o,
    output logic [31:0] rf_wdata_lsu_o
);

    lsu_state_e  state_q, state_d;
    logic        we_q, sign_q, err_q;
    lsu_type_e   type_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    // In IDLE the request is issued straight from the inputs; afterwards
    // everything comes from the captured copy.
    logic        idle;
    logic        cur_we, cur_sign;
    lsu_type_e   cur_type;
    logic [1:0]  cur_off;
    logic [31:0] cur_addr, cur_wdata;
    logic        misal, split;
    logic [31:0] addr_a, addr_b;
    logic [63:0] wdata_dbl;
    logic [31:0] wdata_rot;
    logic [31:0] align_res;

    assign idle      = (state_q == IDLE);
    assign cur_we    = idle ? lsu_we_i       : we_q;
    assign cur_sign  = idle ? lsu_sign_ext_i : sign_q;
    assign cur_type  = idle ? lsu_type_i     : type_q;
    assign cur_off   = idle ? lsu_addr_i[1:0] : off_q;
    assign cur_addr  = idle ? lsu_addr_i     : addr_q;
    assign cur_wdata = idle ? lsu_wdata_i    : wdata_q;

    assign misal  = ((cur_type == LSU_WORD) && (cur_off != 2'd0)) ||
                    ((cur_type == LSU_HALF) && (cur_off == 2'd3));
    assign split  = MisalignEn & misal;
    assign addr_a = {cur_addr[31:2], 2'b00};
    assign addr_b = addr_a + 32'd4;

    // Rotate left by 8*off: upper half of the doubled word after the shift.
    assign wdata_dbl = {cur_wdata, cur_wdata} << {cur_off, 3'b000};
    assign wdata_rot = wdata_dbl[63:32];

    brq_lsu_load_align u_load_align (
        .rdata_i    (data_rdata_i),
        .rdata_q_i  (rdata_q),
        .split_i    (split),
        .off_i      (cur_off),
        .type_i     (cur_type),
        .sign_ext_i (cur_sign),
        .result_o   (align_res)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            type_q  <= LSU_WORD;
            off_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (idle && lsu_req_i) begin
                we_q    <= lsu_we_i;
                sign_q  <= lsu_sign_ext_i;
                type_q  <= lsu_type_i;
                off_q   <= lsu_addr_i[1:0];
                addr_q  <= lsu_addr_i;
                wdata_q <= lsu_wdata_i;
                err_q   <= 1'b0;
            end
            if ((state_q == WAIT_RVALID_A) && data_rvalid_i && split) begin
                rdata_q <= data_rdata_i;
                err_q   <= data_err_i;
            end
        end
    end

    logic complete;
    logic phase_b;

    always_comb begin
        state_d        = state_q;
        data_req_o     = 1'b0;
        phase_b        = 1'b0;
        lsu_req_done_o = 1'b0;
        complete       = 1'b0;
        if (rst_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        data_req_o     = 1'b1;
                        lsu_req_done_o = data_gnt_i & ~split;
                        state_d        = data_gnt_i ? WAIT_RVALID_A : WAIT_GNT_A;
                    end
                end
                WAIT_GNT_A: begin
                    data_req_o     = 1'b1;
                    lsu_req_done_o = data_gnt_i & ~split;
                    if (data_gnt_i) state_d = WAIT_RVALID_A;
                end
                WAIT_RVALID_A: begin
                    if (data_rvalid_i) begin
                        if (split) begin
                            // Phase B goes out in the same cycle phase A returns.
                            data_req_o     = 1'b1;
                            phase_b        = 1'b1;
                            lsu_req_done_o = data_gnt_i;
                            state_d        = data_gnt_i ? WAIT_RVALID_B : WAIT_GNT_B;
                        end else begin
                            complete = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end
                WAIT_GNT_B: begin
                    data_req_o     = 1'b1;
                    phase_b        = 1'b1;
                    lsu_req_done_o = data_gnt_i;
                    if (data_gnt_i) state_d = WAIT_RVALID_B;
                end
                WAIT_RVALID_B: begin
                    if (data_rvalid_i) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_o       = ~rst_i & ~idle;
    assign data_addr_o  = data_req_o ? (phase_b ? addr_b : addr_a) : 32'd0;
    assign data_be_o    = data_req_o ? lsu_be(cur_type, cur_off, phase_b) : 4'b0000;
    assign data_we_o    = data_req_o & cur_we;
    assign data_wdata_o = data_req_o ? wdata_rot : 32'd0;

    // Unsplit misalignment (MisalignEn=0) is reported as an error at completion.
    assign lsu_resp_valid_o = complete;
    assign lsu_resp_err_o   = complete & (data_err_i | err_q | (~MisalignEn & misal));
    assign rf_we_lsu_o      = complete & ~cur_we & ~lsu_resp_err_o;
    assign rf_wdata_lsu_o   = rf_we_lsu_o ? align_res : 32'd0;

endmodule

// File: tb/tb_brq_lsu_resp_unit.sv
module tb_brq_lsu_resp_unit;
    import brq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
    lsu_type_e   lsu_type_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_req_done_o, busy_o;
    logic        data_req_o, data_gnt_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;
    logic        lsu_resp_valid_o, lsu_resp_err_o, rf_we_lsu_o;
    logic [31:0] rf_wdata_lsu_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    brq_lsu_resp_unit #(.MisalignEn(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
        .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_req_done_o(lsu_req_done_o), .busy_o(busy_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_err_o(lsu_resp_err_o),
        .rf_we_lsu_o(rf_we_lsu_o), .rf_wdata_lsu_o(rf_wdata_lsu_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk_i);
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = 32'd0;
    endtask

    task automatic set_req(input logic we, input lsu_type_e t, input logic sx,
                           input logic [31:0] addr, input logic [31:0] wd);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = t;
        lsu_sign_ext_i = sx; lsu_addr_i = addr; lsu_wdata_i = wd;
    endtask

    // Aligned/non-split load: grant immediately, response next cycle.
    task automatic single_load(input string tag, input lsu_type_e t, input logic sx,
                               input logic [31:0] addr, input logic [31:0] rd,
                               input logic [3:0] exp_be, input logic [31:0] exp_wd);
        next_cycle();
        set_req(1'b0, t, sx, addr, 32'd0);
        data_gnt_i = 1'b1;
        #1;
        chk({tag, "_req"},  {31'd0, data_req_o}, 32'd1);
        chk({tag, "_addr"}, data_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_be"},   {28'd0, data_be_o}, {28'd0, exp_be});
        chk({tag, "_done"}, {31'd0, lsu_req_done_o}, 32'd1);
        next_cycle();
        lsu_req_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = rd;
        #1;
        chk({tag, "_vld"},  {31'd0, lsu_resp_valid_o}, 32'd1);
        chk({tag, "_rfwe"}, {31'd0, rf_we_lsu_o}, 32'd1);
        chk({tag, "_rfwd"}, rf_wdata_lsu_o, exp_wd);
    endtask

    initial begin
        rst_i = 1'b1;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = LSU_WORD; lsu_sign_ext_i = 1'b0;
        lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'd0;

        // Reset: outputs stay low even with a request and bus activity present.
        repeat (2) @(negedge clk_i);
        set_req(1'b0, LSU_WORD, 1'b0, 32'h100, 32'd0);
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
        #1;
        chk("rst_req",  {31'd0, data_req_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_vld",  {31'd0, lsu_resp_valid_o}, 32'd0);
        chk("rst_done", {31'd0, lsu_req_done_o}, 32'd0);
        next_cycle();
        rst_i = 1'b0; lsu_req_i = 1'b0;

        // Aligned word load, response two cycles after issue.
        next_cycle();
        set_req(1'b0, LSU_WORD, 1'b0, 32'h100, 32'd0);
        data_gnt_i = 1'b1;
        #1;
        chk("w_addr", data_addr_o, 32'h100);
        chk("w_be",   {28'd0, data_be_o}, 32'hF);
        chk("w_done", {31'd0, lsu_req_done_o}, 32'd1);
        next_cycle();
        lsu_req_i = 1'b0;
        #1;
        chk("w_busy", {31'd0, busy_o}, 32'd1);
        chk("w_novld", {31'd0, lsu_resp_valid_o}, 32'd0);
        next_cycle();
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
        #1;
        chk("w_vld",  {31'd0, lsu_resp_valid_o}, 32'd1);
        chk("w_err",  {31'd0, lsu_resp_err_o}, 32'd0);
        chk("w_rfwe", {31'd0, rf_we_lsu_o}, 32'd1);
        chk("w_rfwd", rf_wdata_lsu_o, 32'hDEADBEEF);
        next_cycle();
        #1;
        chk("w_pulse", {31'd0, lsu_resp_valid_o}, 32'd0);
        chk("w_idle",  {31'd0, busy_o}, 32'd0);

        // Byte / half loads with extension.
        single_load("bs", LSU_BYTE, 1'b1, 32'h103, 32'h80123456, 4'b1000, 32'hFFFFFF80);
        single_load("bz", LSU_BYTE, 1'b0, 32'h103, 32'h80123456, 4'b1000, 32'h00000080);
        single_load("hs", LSU_HALF, 1'b1, 32'h102, 32'hBEEF1234, 4'b1100, 32'hFFFFBEEF);
        single_load("b1", LSU_BYTE, 1'b1, 32'h101, 32'h00007F00, 4'b0010, 32'h0000007F);

        // Misaligned word store split over two transactions.
        next_cycle();
        set_req(1'b1, LSU_WORD, 1'b0, 32'h102, 32'h11223344);
        data_gnt_i = 1'b1;
        #1;
        chk("st_a_addr", data_addr_o, 32'h100);
        chk("st_a_be",   {28'd0, data_be_o}, 32'hC);
        chk("st_a_wd",   data_wdata_o, 32'h33441122);
        chk("st_a_we",   {31'd0, data_we_o}, 32'd1);
        chk("st_a_done", {31'd0, lsu_req_done_o}, 32'd0);
        next_cycle();
        data_rvalid_i = 1'b1;
        #1;
        chk("st_b_req",  {31'd0, data_req_o}, 32'd1);
        chk("st_b_addr", data_addr_o, 32'h104);
        chk("st_b_be",   {28'd0, data_be_o}, 32'h3);
        chk("st_b_wd",   data_wdata_o, 32'h33441122);
        chk("st_b_novld", {31'd0, lsu_resp_valid_o}, 32'd0);
        next_cycle();
        data_gnt_i = 1'b1;
        #1;
        chk("st_b_done", {31'd0, lsu_req_done_o}, 32'd1);
        next_cycle();
        lsu_req_i = 1'b0;
        data_rvalid_i = 1'b1;
        #1;
        chk("st_vld",  {31'd0, lsu_resp_valid_o}, 32'd1);
        chk("st_rfwe", {31'd0, rf_we_lsu_o}, 32'd0);
        chk("st_err",  {31'd0, lsu_resp_err_o}, 32'd0);

        // Misaligned half load across a word boundary.
        next_cycle();
        set_req(1'b0, LSU_HALF, 1'b0, 32'h0FF, 32'd0);
        data_gnt_i = 1'b1;
        #1;
        chk("h_a_addr", data_addr_o, 32'h0FC);
        chk("h_a_be",   {28'd0, data_be_o}, 32'h8);
        next_cycle();
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hAB000000;
        #1;
        chk("h_b_addr", data_addr_o, 32'h100);
        chk("h_b_be",   {28'd0, data_be_o}, 32'h1);
        chk("h_b_done", {31'd0, lsu_req_done_o}, 32'd1);
        next_cycle();
        lsu_req_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h000000CD;
        #1;
        chk("h_vld",  {31'd0, lsu_resp_valid_o}, 32'd1);
        chk("h_rfwd", rf_wdata_lsu_o, 32'h0000CDAB);

        // Split load: grant withheld 3 cycles, error on phase A only.
        next_cycle();
        set_req(1'b0, LSU_WORD, 1'b0, 32'h201, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                data_rvalid_i = 1'b1; data_err_i = 1'b1;
            end
            #1;
            chk("eg_req",  {31'd0, data_req_o}, 32'd1);
            chk("eg_addr", data_addr_o, 32'h200);
            chk("eg_be",   {28'd0, data_be_o}, 32'hE);
            chk("eg_novld", {31'd0, lsu_resp_valid_o}, 32'd0);
            next_cycle();
        end
        data_gnt_i = 1'b1;
        #1;
        chk("eg_a_done", {31'd0, lsu_req_done_o}, 32'd0);
        next_cycle();
        data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = 32'h12345678;
        #1;
        chk("e_b_req",  {31'd0, data_req_o}, 32'd1);
        chk("e_b_addr", data_addr_o, 32'h204);
        chk("e_b_be",   {28'd0, data_be_o}, 32'h1);
        next_cycle();
        data_gnt_i = 1'b1;
        #1;
        chk("e_b_done", {31'd0, lsu_req_done_o}, 32'd1);
        next_cycle();
        lsu_req_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h9ABCDEF0;
        #1;
        chk("e_vld",  {31'd0, lsu_resp_valid_o}, 32'd1);
        chk("e_err",  {31'd0, lsu_resp_err_o}, 32'd1);
        chk("e_rfwe", {31'd0, rf_we_lsu_o}, 32'd0);
        chk("e_rfwd", rf_wdata_lsu_o, 32'd0);

        // Reset while waiting for rvalid abandons the transaction.
        next_cycle();
        set_req(1'b0, LSU_WORD, 1'b0, 32'h300, 32'd0);
        data_gnt_i = 1'b1;
        next_cycle();
        lsu_req_i = 1'b0;
        rst_i = 1'b1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h55555555;
        #1;
        chk("r_vld_in_rst", {31'd0, lsu_resp_valid_o}, 32'd0);
        chk("r_busy_in_rst", {31'd0, busy_o}, 32'd0);
        next_cycle();
        rst_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h55555555;
        #1;
        chk("r_busy", {31'd0, busy_o}, 32'd0);
        chk("r_late_vld", {31'd0, lsu_resp_valid_o}, 32'd0);
        chk("r_late_rfwe", {31'd0, rf_we_lsu_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/brq_lsu_resp_unit.md
Name: brq_lsu_resp_unit

Overview:
- Load/store bus engine that produces the response side consumed by the writeback stage: lsu_resp_valid, lsu_resp_err, rf_we_lsu and rf_wdata_lsu.
- Accepts one load/store from ID/EX and drives the data-memory req/gnt/rvalid interface.
- Splits misaligned accesses into two word-aligned bus transactions.
- Aligns and sign- or zero-extends load data.

Parameters:
- MisalignEn, 1'b1: 1 = split misaligned accesses into two transactions; 0 = issue a single aligned access and flag lsu_resp_err_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- lsu_req_i  in  1  request valid from ID/EX; upstream holds it stable until lsu_req_done_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_type_i  in  2  lsu_type_e: word, half or byte
- lsu_sign_ext_i  in  1  sign-extend load data
- lsu_addr_i  in  32  byte address
- lsu_wdata_i  in  32  store data, LSB-aligned
- lsu_req_done_o  out  1  request accepted (grant of the final phase)
- busy_o  out  1  state != IDLE
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  32  word-aligned bus address
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  rotated store data
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus error, qualified by rvalid
- data_rdata_i  in  32  bus read data
- lsu_resp_valid_o  out  1  one-cycle pulse when the transaction completes
- lsu_resp_err_o  out  1  error, qualified by lsu_resp_valid_o
- rf_we_lsu_o  out  1  load result write enable
- rf_wdata_lsu_o  out  32  aligned and extended load data

Behaviour:
- States: IDLE, WAIT_GNT_A, WAIT_RVALID_A, WAIT_GNT_B, WAIT_RVALID_B.
- off = addr[1:0]. split = MisalignEn & ((word & off != 0) | (half & off == 3)).
- IDLE with lsu_req_i:
  - Drive data_req_o combinationally; addr = {addr[31:2], 2'b00}.
  - Capture we, type, sign_ext, off, wdata and addr into registers.
  - gnt=1 -> WAIT_RVALID_A. gnt=0 -> WAIT_GNT_A, which holds req and all bus outputs from the captured registers.
- WAIT_RVALID_A, on rvalid:
  - Non-split: complete the transaction and go to IDLE.
  - Split: store rdata_q and err_q; re-assert req at addr+4 (aligned) the same cycle. gnt -> WAIT_RVALID_B, else WAIT_GNT_B.
- WAIT_RVALID_B, on rvalid: complete the transaction; go to IDLE.
- lsu_req_done_o: asserted in the cycle data_gnt_i is high during the final phase (phase A if non-split, else phase B).
- New requests are accepted only in IDLE. There is no back-to-back overlap: IDLE is re-entered in the cycle after completion.
- data_rvalid_i in IDLE or in any WAIT_GNT state is ignored.
- Byte enables (phase A / phase B):
  - word: 4'b1111<<off / 4'b1111>>(4-off)
  - half: 4'b0011<<off; at off=3, 4'b1000 / 4'b0001
  - byte: 4'b0001<<off
- Store data: wdata rotated left by 8*off, identical in both phases.
- Load data:
  - raw = split ? ({rdata_B, rdata_q} >> 8*off)[31:0] : rdata >> 8*off.
  - Truncate raw to 8/16/32 bits, then sign- or zero-extend.
- Completion (combinational, in the same cycle as the final rvalid):
  - lsu_resp_valid_o=1.
  - lsu_resp_err_o = data_err_i | err_q.
  - rf_we_lsu_o = ~we & ~lsu_resp_err_o.
  - rf_wdata_lsu_o valid only when rf_we_lsu_o=1; otherwise 0.
- Error in phase A of a split: phase B is still issued; the error is reported at completion and no RF write occurs.
- MisalignEn=0 with a misaligned access: issue a single aligned transaction; force lsu_resp_err_o=1 at completion.
- Reset:
  - rst_i forces state to IDLE and clears err_q and rdata_q.
  - While rst_i=1, all outputs are 0, including combinational ones.
  - Reset mid-transaction abandons it; no response is generated.

Decomposition:
- brq_pkg: add lsu_type_e (LSU_WORD=2'b00, LSU_HALF=2'b01, LSU_BYTE=2'b10) and lsu_state_e.
- Sub-module brq_lsu_load_align: combinational, rdata/rdata_q/off/type/sign -> 32-bit result.

Test Plan:
- Aligned word load, addr 0x100, gnt same cycle, rvalid 2 cycles later with 0xDEADBEEF -> be=4'hF; one resp pulse; rf_we=1; wdata=0xDEADBEEF.
- Byte load signed, addr 0x103, rdata 0x80xxxxxx -> be=4'b1000; rf_wdata=0xFFFFFF80. Same access with sign=0 -> 0x00000080.
- Misaligned word store, addr 0x102, wdata 0x11223344:
  - Phase A: addr 0x100, be=4'b1100, wdata=0x33441122.
  - Phase B: addr 0x104, be=4'b0011.
  - One resp pulse; rf_we=0.
- Misaligned half load, addr 0x0FF:
  - Phase A: rdata 0xAB000000. Phase B: rdata 0x000000CD.
  - rf_wdata=0x0000CDAB (zero-extended).
- Split load with err on phase A only -> phase B still issued; resp_err=1; rf_we=0. Gnt withheld for 3 cycles -> addr, be and req held stable.
- rst_i asserted in WAIT_RVALID_A -> next cycle IDLE and busy_o=0; a late rvalid produces no resp pulse.
